// File: rtl/seg7_count_monitor_if.sv
// seg7_count_monitor_if: segment bus and mode bits in, monitor results out.
// master drives the display side, slave is the monitor.
interface seg7_count_monitor_if #(
  parameter int CNT_W = 8
);
  logic [0:6]       seg;
  logic             w1;
  logic             w0;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             step_error;
  logic             bad_pattern;
  logic             error_sticky;
  logic [CNT_W-1:0] match_count;

  modport master (
    output seg,
    output w1,
    output w0,
    input  digit,
    input  digit_valid,
    input  step_error,
    input  bad_pattern,
    input  error_sticky,
    input  match_count
  );

  modport slave (
    input  seg,
    input  w1,
    input  w0,
    output digit,
    output digit_valid,
    output step_error,
    output bad_pattern,
    output error_sticky,
    output match_count
  );
endinterface

// File: rtl/seg7_count_monitor.sv
// seg7_count_monitor: stability-filters an active-low 7-seg bus, decodes it
// and checks each accepted digit against a mod-ten step. SEG7_HEX_AF_EN adds A-F.
module seg7_count_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                clk,
  input logic                rst_n,
  seg7_count_monitor_if.slave bus
);

`ifdef SEG7_HEX_AF_EN
  localparam bit HEX_AF = 1'b1;
`else
  localparam bit HEX_AF = 1'b0;
`endif

  localparam logic [3:0]       STAB    = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_ERROR
  } state_t;

  state_t           state;
  logic [0:6]       prev_seg;
  logic [0:6]       last_seg;
  logic [3:0]       stab_cnt;
  logic [3:0]       stab_nxt;
  logic             held;
  logic             accept;

  logic [3:0]       digit_q;
  logic             valid_q;
  logic             step_err_q;
  logic             bad_pat_q;
  logic             sticky_q;
  logic [CNT_W-1:0] match_q;

  logic             dec_legal;
  logic             dec_letter;
  logic [3:0]       dec_val;
  logic [3:0]       add;
  logic [4:0]       sum;
  logic [3:0]       exp_val;

  // held: this edge repeats the previous sample of an unbroken run
  assign held = (stab_cnt != 4'd0) && (bus.seg == prev_seg);

  always_comb begin
    stab_nxt = 4'd1;
    if (held) begin
      stab_nxt = (stab_cnt == STAB) ? STAB : stab_cnt + 4'd1;
    end
  end

  assign accept = (stab_nxt == STAB)
               && !(held && (stab_cnt == STAB))
               && (bus.seg != last_seg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg <= '1;
      stab_cnt <= 4'd0;
      last_seg <= '1;
    end else begin
      prev_seg <= bus.seg;
      stab_cnt <= stab_nxt;
      if (accept) begin
        last_seg <= bus.seg;
      end
    end
  end

  always_comb begin
    dec_legal  = 1'b1;
    dec_letter = 1'b0;
    dec_val    = 4'd0;
    case (bus.seg)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      7'b0001000: begin
        dec_val = 4'd10; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      7'b1100000: begin
        dec_val = 4'd11; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      7'b0110001: begin
        dec_val = 4'd12; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      7'b1000010: begin
        dec_val = 4'd13; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      7'b0110000: begin
        dec_val = 4'd14; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      7'b0111000: begin
        dec_val = 4'd15; dec_legal = HEX_AF; dec_letter = HEX_AF;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // -1 is taken as +9 so every mode is a plain add mod 10
  always_comb begin
    unique case ({bus.w1, bus.w0})
      2'b00:   add = 4'd0;
      2'b01:   add = 4'd1;
      2'b10:   add = 4'd2;
      default: add = 4'd9;
    endcase
    sum     = {1'b0, digit_q} + {1'b0, add};
    exp_val = 4'(sum % 5'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      digit_q    <= 4'd0;
      valid_q    <= 1'b0;
      step_err_q <= 1'b0;
      bad_pat_q  <= 1'b0;
      sticky_q   <= 1'b0;
      match_q    <= '0;
    end else begin
      step_err_q <= 1'b0;
      bad_pat_q  <= 1'b0;
      if (accept) begin
        if (!dec_legal) begin
          bad_pat_q <= 1'b1;
          sticky_q  <= 1'b1;
          if (state == S_TRACK) begin
            state <= S_ERROR;
          end
        end else begin
          digit_q <= dec_val;
          valid_q <= 1'b1;
          unique case (state)
            S_TRACK: begin
              if (!dec_letter && (dec_val == exp_val)) begin
                if (match_q != CNT_MAX) begin
                  match_q <= match_q + 1'b1;
                end
              end else begin
                step_err_q <= 1'b1;
                sticky_q   <= 1'b1;
                state      <= S_ERROR;
              end
            end
            default: state <= S_TRACK;
          endcase
        end
      end
    end
  end

  assign bus.digit        = digit_q;
  assign bus.digit_valid  = valid_q;
  assign bus.step_error   = step_err_q;
  assign bus.bad_pattern  = bad_pat_q;
  assign bus.error_sticky = sticky_q;
  assign bus.match_count  = match_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// tb_seg7_count_monitor: random and directed stimulus against a
// window-based behavioural model of the monitor.
module tb_seg7_count_monitor;
  localparam int S    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_count_monitor_if #(.CNT_W(CW)) bus ();

  seg7_count_monitor #(
    .STABLE_CYCLES(S),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [0:6] dig_pat [10];
  logic [0:6] lt_pat [6];

  logic [0:6] hist [$];
  logic [0:6] m_last;
  int m_state;
  int m_digit, m_valid, m_se, m_bp, m_sticky, m_cnt;
  int se_seen, bp_seen;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [0:6] p);
    for (int i = 0; i < 10; i++) if (dig_pat[i] == p) return i;
`ifdef SEG7_HEX_AF_EN
    for (int i = 0; i < 6; i++) if (lt_pat[i] == p) return 10 + i;
`endif
    return -1;
  endfunction

  function automatic int step_of();
    int mode;
    mode = 2 * int'(bus.w1) + int'(bus.w0);
    return (mode == 3) ? -1 : mode;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_last = 7'b1111111;
    m_state = 0;
    m_digit = 0; m_valid = 0; m_se = 0; m_bp = 0;
    m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [0:6] p;
    bit now_st, prev_st;
    int v, expv, n;
    p = bus.seg;
    m_se = 0;
    m_bp = 0;
    hist.push_back(p);
    if (hist.size() > S + 1) void'(hist.pop_front());
    n = hist.size();
    now_st = (n >= S);
    if (now_st) for (int i = n - S; i < n; i++) if (hist[i] != p) now_st = 0;
    prev_st = (n == S + 1);
    if (prev_st) for (int i = 0; i < S; i++) if (hist[i] != hist[0]) prev_st = 0;
    if (now_st && !prev_st && p != m_last) begin
      m_last = p;
      v = decode(p);
      if (v < 0) begin
        m_bp = 1;
        m_sticky = 1;
        if (m_state == 1) m_state = 2;
      end else begin
        expv = ((m_digit + step_of()) % 10 + 10) % 10;
        if (m_state == 1) begin
          if (v == expv) begin
            if (m_cnt < CMAX) m_cnt++;
          end else begin
            m_se = 1;
            m_sticky = 1;
            m_state = 2;
          end
        end else begin
          m_state = 1;
        end
        m_digit = v;
        m_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("digit", int'(bus.digit), m_digit);
    chk("digit_valid", int'(bus.digit_valid), m_valid);
    chk("step_error", int'(bus.step_error), m_se);
    chk("bad_pattern", int'(bus.bad_pattern), m_bp);
    chk("error_sticky", int'(bus.error_sticky), m_sticky);
    chk("match_count", int'(bus.match_count), m_cnt);
    chk("pulse_excl", int'(bus.step_error & bus.bad_pattern), 0);
    se_seen |= int'(bus.step_error);
    bp_seen |= int'(bus.bad_pattern);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [0:6] p, input int n);
    bus.seg = p;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic set_mode(input int m);
    bus.w1 = m[1];
    bus.w0 = m[0];
  endtask

  initial begin
    logic [0:6] bad;
    int r, nd, len;
    dig_pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    lt_pat  = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
                7'b0111000};
    bus.seg = 7'b1111111;
    set_mode(0);
    se_seen = 0;
    bp_seen = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    do_reset();

    hold(dig_pat[0], 4);
    chk("lit_first_digit", int'(bus.digit), 0);
    chk("lit_first_valid", int'(bus.digit_valid), 1);
    chk("lit_first_cnt", int'(bus.match_count), 0);
    hold(dig_pat[0], 5);
    chk("lit_hold_cnt", int'(bus.match_count), 0);

    set_mode(1);
    for (int d = 1; d <= 10; d++) hold(dig_pat[d % 10], 4);
    chk("lit_up_cnt", int'(bus.match_count), 10);
    chk("lit_up_digit", int'(bus.digit), 0);
    chk("lit_up_no_se", se_seen, 0);

    set_mode(3);
    hold(dig_pat[9], 4);
    chk("lit_dn_cnt", int'(bus.match_count), 11);
    hold(dig_pat[7], 4);
    chk("lit_dn_se", int'(bus.step_error), 1);
    chk("lit_dn_sticky", int'(bus.error_sticky), 1);
    tick();
    chk("lit_dn_se_once", int'(bus.step_error), 0);
    se_seen = 0;
    hold(dig_pat[6], 4);
    chk("lit_resync_digit", int'(bus.digit), 6);
    chk("lit_resync_no_se", se_seen, 0);
    hold(dig_pat[5], 4);
    chk("lit_track_cnt", int'(bus.match_count), 12);

    se_seen = 0;
    bp_seen = 0;
    for (int k = 0; k < 6; k++) hold(dig_pat[(k % 2) ? 4 : 3], 2);
    chk("lit_glitch_digit", int'(bus.digit), 5);
    chk("lit_glitch_pulses", se_seen + bp_seen, 0);

    bad = 7'b1111110;
    hold(bad, 4);
    chk("lit_bad_bp", int'(bus.bad_pattern), 1);
    chk("lit_bad_digit", int'(bus.digit), 5);
    tick();
    chk("lit_bad_once", int'(bus.bad_pattern), 0);
    hold(dig_pat[4], 4);

`ifdef SEG7_HEX_AF_EN
    set_mode(1);
    hold(dig_pat[5], 4);
    hold(lt_pat[0], 4);
    chk("lit_hex_digit", int'(bus.digit), 10);
    chk("lit_hex_se", int'(bus.step_error), 1);
    chk("lit_hex_bp", int'(bus.bad_pattern), 0);
`endif

    set_mode(0);
    hold(dig_pat[2], 3);
    do_reset();
    chk("lit_rst_valid", int'(bus.digit_valid), 0);
    chk("lit_rst_sticky", int'(bus.error_sticky), 0);
    hold(dig_pat[2], 3);
    chk("lit_rst_partial", int'(bus.digit_valid), 0);
    tick();
    chk("lit_rst_digit", int'(bus.digit), 2);
    chk("lit_rst_nocheck", int'(bus.step_error), 0);

    do_reset();
    set_mode(1);
    hold(dig_pat[0], 4);
    for (int k = 1; k <= 260; k++) hold(dig_pat[k % 10], 4);
    chk("lit_sat_cnt", int'(bus.match_count), CMAX);

    do_reset();
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        nd = ((m_digit + step_of()) % 10 + 10) % 10;
        bus.seg = dig_pat[nd];
      end else if (r < 16) begin
        bus.seg = dig_pat[$urandom_range(0, 9)];
      end else if (r < 18) begin
        bus.seg = 7'($urandom_range(0, 127));
      end else begin
        bus.seg = lt_pat[$urandom_range(0, 5)];
      end
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 7);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) set_mode($urandom_range(0, 3));
        tick();
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_count_monitor.md
Name: seg7_count_monitor

Overview:
- Receive-side checker for the counter-to-display path.
- Samples an active-low 7-segment pattern bus, filters it for stability, and decodes it back to a 4-bit digit.
- Checks every displayed transition against the expected mod-ten step selected by the w1/w0 mode bits.
- Used as an on-board self-check beside the hex display and as a bench monitor for the counter.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples before a pattern is accepted (legal range 1-15).
- CNT_W, 8, width of the saturating match counter.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- seg  input  [0:6]  segment pattern, active-low; seg[0]=a through seg[6]=g.
- w1  input  1  mode bit 1.
- w0  input  1  mode bit 0.
- digit  output  4  last accepted decoded digit.
- digit_valid  output  1  high once any legal digit has been accepted.
- step_error  output  1  one-cycle pulse on an illegal transition.
- bad_pattern  output  1  one-cycle pulse on an accepted, undecodable pattern.
- error_sticky  output  1  set by any error; cleared only by Reset.
- match_count  output  CNT_W  count of correct transitions, saturating.

Behaviour:
- Reset (Reset=0, asynchronous): all outputs are 0; stability counter is 0; last-accepted pattern register is all-ones (blank); FSM enters IDLE.
- Stability filter:
  - A pattern is "stable" when seg has equal values on STABLE_CYCLES consecutive rising edges, counting the current edge.
  - Any change restarts the count at 1.
  - An accept event occurs on the edge where the pattern becomes stable AND differs from the last-accepted pattern.
  - Once stable, the pattern generates no further events until it changes.
- Decode table (seg[0..6], active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other pattern is illegal. All-ones (blank) is also illegal, except that it never triggers an accept while it equals the reset value of the last-accepted register.
- Expected step, with w1 and w0 sampled on the accept edge:
  - 00: hold, so any change is an error.
  - 01: +1
  - 10: +2
  - 11: -1
  - Arithmetic is mod 10, so 9+1=0, 8+2=0, 9+2=1, 0-1=9.
- FSM states: IDLE, TRACK, ERROR. All outputs are registered; each updates on the accept edge and is visible after that edge, so latency is STABLE_CYCLES edges from the seg change.
  - IDLE:
    - Legal accept: load digit, set digit_valid, go to TRACK. No step check is made.
    - Illegal accept: pulse bad_pattern, set error_sticky, stay in IDLE.
  - TRACK:
    - Legal accept equal to the expected value: load digit, increment match_count (saturates at 2^CNT_W-1 with no wrap), stay in TRACK.
    - Legal accept not equal to the expected value: load digit, pulse step_error, set error_sticky, go to ERROR.
    - Illegal accept: pulse bad_pattern, set error_sticky, go to ERROR; digit holds.
  - ERROR:
    - Legal accept: resynchronise by loading digit and returning to TRACK, with no step check.
    - Illegal accept: pulse bad_pattern again and stay in ERROR.
- Simultaneous events: w1/w0 changing on the accept edge takes its new value on that edge. step_error and bad_pattern are never both high.
- Reset asserted mid-filter discards the partial count; the first accept after release is treated as from IDLE.

Optional Feature:
- Macro: SEG7_HEX_AF_EN.
- When defined, the decoder also accepts the hex letters:
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - These decode to 10-15. A letter accept loads digit and sets digit_valid, but in TRACK it always pulses step_error, because no mod-ten step can reach it. It never pulses bad_pattern.
- When not defined, these six patterns are illegal and pulse bad_pattern.

Test Plan:
- Reset, then seg=0000001 held for 4 cycles -> after the 4th edge digit=0, digit_valid=1, match_count=0, no error pulses; holding further produces no further accept.
- Mode 01, sequence 0,1,...,9,0, each held 4 cycles -> match_count=10, step_error never high, digit ends at 0 (9->0 wrap accepted).
- Mode 11 from digit 0, apply 9 then 7 -> 9 counted as a match; 7 pulses step_error for exactly one cycle, error_sticky=1, FSM in ERROR; then apply 6 -> digit=6, no pulse, back in TRACK.
- Glitch: seg toggles between 3 and 4 every 2 cycles with STABLE_CYCLES=4 -> no accept, all outputs unchanged.
- Stable pattern 1111110 -> bad_pattern one-cycle pulse, digit holds, error_sticky=1; with SEG7_HEX_AF_EN, pattern 0001000 in TRACK -> digit=10 and a step_error pulse.
- Reset pulsed low for 1 cycle mid-way through a 3-of-4 stable count -> all outputs 0; a fresh 4-cycle hold is needed to accept, and that accept is not step-checked.
